// File: rtl/niu_pkg.sv
// Shared NIU definitions: word size, ALU opcode map and iterative-engine types.
// Both the ALU and the CPU decode against these constants.
package niu_pkg;

  localparam int WORD_SIZE = 32;

  localparam logic [4:0] OP2_ADD    = 5'b00000;
  localparam logic [4:0] OP2_SUB    = 5'b00001;
  localparam logic [4:0] OP2_NOT    = 5'b00010;
  localparam logic [4:0] OP2_AND    = 5'b00011;
  localparam logic [4:0] OP2_OR     = 5'b00100;
  localparam logic [4:0] OP2_XOR    = 5'b00101;
  localparam logic [4:0] OP2_SUL    = 5'b00110;
  localparam logic [4:0] OP2_SSL    = 5'b00111;
  localparam logic [4:0] OP2_SUR    = 5'b01000;
  localparam logic [4:0] OP2_SSR    = 5'b01001;
  localparam logic [4:0] OP2_EQ     = 5'b01010;
  localparam logic [4:0] OP2_NEQ    = 5'b01011;
  localparam logic [4:0] OP2_LT     = 5'b01101;
  localparam logic [4:0] OP2_LEQ    = 5'b01110;
  localparam logic [4:0] OP2_MLT    = 5'b01111;
  localparam logic [4:0] OP2_DIV    = 5'b10000;
  localparam logic [4:0] OP3_BITSEL = 5'b11111;

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} alu_state_t;
  typedef enum logic {MODE_MUL, MODE_DIV} iter_mode_t;

  function automatic logic op_defined(input logic [4:0] f);
    case (f)
      OP2_ADD, OP2_SUB, OP2_NOT, OP2_AND, OP2_OR, OP2_XOR,
      OP2_SUL, OP2_SSL, OP2_SUR, OP2_SSR, OP2_EQ, OP2_NEQ,
      OP2_LT, OP2_LEQ, OP2_MLT, OP2_DIV, OP3_BITSEL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/niu_iter_muldiv.sv
// One-bit-per-cycle shift-add multiplier / restoring divider on magnitudes.
// The first iteration happens on the start edge, so done pulses WIDTH cycles after start.
module niu_iter_muldiv
  import niu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  iter_mode_t       mode,
  input  logic [WIDTH-1:0] mag_a,
  input  logic [WIDTH-1:0] mag_b,
  input  logic             sign,
  output logic [WIDTH-1:0] value,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);

  iter_mode_t       mode_reg, cur_mode;
  logic             sign_reg, running_reg, done_reg;
  logic [CNT_W-1:0] count_reg;
  logic [WIDTH-1:0] acc_reg, x_reg, y_reg;
  logic [WIDTH-1:0] cur_acc, cur_x, cur_y;
  logic [WIDTH-1:0] acc_next, x_next, y_next;
  logic [WIDTH:0]   shifted, trial;

  // MUL: acc=product, x=multiplicand, y=multiplier.
  // DIV: acc=dividend shifting out / quotient shifting in, x=remainder, y=divisor.
  always_comb begin
    cur_mode = running_reg ? mode_reg : mode;
    cur_acc  = '0;
    cur_x    = '0;
    cur_y    = '0;
    acc_next = '0;
    x_next   = '0;
    y_next   = '0;
    shifted  = '0;
    trial    = '0;
    if (cur_mode == MODE_MUL) begin
      cur_acc  = running_reg ? acc_reg : '0;
      cur_x    = running_reg ? x_reg : mag_a;
      cur_y    = running_reg ? y_reg : mag_b;
      acc_next = cur_acc + (cur_y[0] ? cur_x : '0);
      x_next   = cur_x << 1;
      y_next   = cur_y >> 1;
    end else begin
      cur_acc = running_reg ? acc_reg : mag_a;
      cur_x   = running_reg ? x_reg : '0;
      cur_y   = running_reg ? y_reg : mag_b;
      shifted = {cur_x, cur_acc[WIDTH-1]};
      trial   = shifted - {1'b0, cur_y};
      y_next  = cur_y;
      if (trial[WIDTH]) begin
        x_next   = shifted[WIDTH-1:0];
        acc_next = {cur_acc[WIDTH-2:0], 1'b0};
      end else begin
        x_next   = trial[WIDTH-1:0];
        acc_next = {cur_acc[WIDTH-2:0], 1'b1};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_reg    <= MODE_MUL;
      sign_reg    <= 1'b0;
      running_reg <= 1'b0;
      done_reg    <= 1'b0;
      count_reg   <= '0;
      acc_reg     <= '0;
      x_reg       <= '0;
      y_reg       <= '0;
    end else begin
      done_reg <= 1'b0;
      if (running_reg) begin
        acc_reg <= acc_next;
        x_reg   <= x_next;
        y_reg   <= y_next;
        if (count_reg == CNT_W'(WIDTH - 1)) begin
          running_reg <= 1'b0;
          done_reg    <= 1'b1;
        end else begin
          count_reg <= count_reg + 1'b1;
        end
      end else if (start) begin
        mode_reg    <= mode;
        sign_reg    <= sign;
        acc_reg     <= acc_next;
        x_reg       <= x_next;
        y_reg       <= y_next;
        count_reg   <= CNT_W'(1);
        running_reg <= 1'b1;
      end
    end
  end

  assign value = sign_reg ? -acc_reg : acc_reg;
  assign done  = done_reg;

endmodule

// File: rtl/niu_mc_alu.sv
// Multi-cycle NIU ALU: single-cycle logic/shift/compare/byte-select ops plus
// iterative MLT and DIV through niu_iter_muldiv.
module niu_mc_alu
  import niu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SHAMT_BITS = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_zero,
  output logic             illegal
);

  localparam int LANES = WIDTH / 8;

  alu_state_t       state_reg, state_next;
  logic             accept, is_mlt, is_div, b_zero, shift_over;
  logic             iter_start, iter_done;
  iter_mode_t       iter_mode;
  logic [WIDTH-1:0] iter_value, alu_value, lane_sel;
  logic [SHAMT_BITS-1:0] shamt;
  logic [7:0]       lane_bytes [LANES];
  logic [7:0]       bitsel_byte;

  assign accept = start && (state_reg == IDLE);
  assign is_mlt = (func == OP2_MLT);
  assign is_div = (func == OP2_DIV);
  assign b_zero = (b == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) begin
        if (is_mlt)                state_next = MUL;
        else if (is_div && !b_zero) state_next = DIV;
        else                        state_next = DONE;
      end
      MUL:     if (iter_done) state_next = DONE;
      DIV:     if (iter_done) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg != IDLE);
    done = (state_reg == DONE);
  end

  // Lane 0 is the most-significant byte of a.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_bytes[gi] = a[WIDTH-1-8*gi -: 8];
    end
  endgenerate

  assign lane_sel   = b % WIDTH'(LANES);
  assign shamt      = b[SHAMT_BITS-1:0];
  assign shift_over = (b >= WIDTH'(WIDTH));

  always_comb begin
    bitsel_byte = '0;
    for (int i = 0; i < LANES; i++)
      if (lane_sel == WIDTH'(i)) bitsel_byte = lane_bytes[i];
  end

  always_comb begin
    alu_value = '0;
    case (func)
      OP2_ADD:          alu_value = a + b;
      OP2_SUB:          alu_value = a - b;
      OP2_NOT:          alu_value = ~a;
      OP2_AND:          alu_value = a & b;
      OP2_OR:           alu_value = a | b;
      OP2_XOR:          alu_value = a ^ b;
      OP2_SUL, OP2_SSL: alu_value = shift_over ? '0 : (a << shamt);
      OP2_SUR:          alu_value = shift_over ? '0 : (a >> shamt);
      OP2_SSR:          alu_value = shift_over ? {WIDTH{a[WIDTH-1]}}
                                               : WIDTH'($signed(a) >>> shamt);
      OP2_EQ:           alu_value = WIDTH'(a == b);
      OP2_NEQ:          alu_value = WIDTH'(a != b);
      OP2_LT:           alu_value = WIDTH'($signed(a) < $signed(b));
      OP2_LEQ:          alu_value = WIDTH'($signed(a) <= $signed(b));
      OP3_BITSEL:       alu_value = WIDTH'(bitsel_byte);
      OP2_DIV:          alu_value = '1;   // only reaches result when b is zero
      default:          alu_value = '0;
    endcase
  end

  assign iter_start = accept && (is_mlt || (is_div && !b_zero));
  assign iter_mode  = is_div ? MODE_DIV : MODE_MUL;

  niu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .reset (reset),
    .start (iter_start),
    .mode  (iter_mode),
    .mag_a (a[WIDTH-1] ? -a : a),
    .mag_b (b[WIDTH-1] ? -b : b),
    .sign  (a[WIDTH-1] ^ b[WIDTH-1]),
    .value (iter_value),
    .done  (iter_done)
  );

  // Result and flags change only on the edge that enters DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result   <= '0;
      div_zero <= 1'b0;
      illegal  <= 1'b0;
    end else if (accept && (state_next == DONE)) begin
      result   <= alu_value;
      div_zero <= is_div && b_zero;
      illegal  <= !op_defined(func);
    end else if ((state_reg == MUL && iter_done) || state_reg == FIX) begin
      result   <= iter_value;
      div_zero <= 1'b0;
      illegal  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_niu_mc_alu.sv
// Scoreboard bench for niu_mc_alu: a 32-bit and a 16-bit instance share clock and reset.
module tb_niu_mc_alu;
  import niu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start32, busy32, done32, dz32, ill32;
  logic [4:0]  func32;
  logic [31:0] a32, b32, result32;
  logic        start16, busy16, done16, dz16, ill16;
  logic [4:0]  func16;
  logic [15:0] a16, b16, result16;

  niu_mc_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .func(func32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .result(result32), .div_zero(dz32), .illegal(ill32));

  niu_mc_alu #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .func(func16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .result(result16), .div_zero(dz16), .illegal(ill16));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       tag;
    logic [63:0] res;
    logic        dz;
    logic        ill;
    int          due;
    int          lat;
  } exp_t;

  exp_t q32[$];
  exp_t q16[$];
  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitors: pop one expectation per done pulse; a done with an empty queue is an error.
  initial begin
    exp_t e;
    int   bcnt = 0;
    forever begin
      @(negedge clk);
      if (reset) bcnt = 0;
      else begin
        if (busy32) bcnt++;
        if (done32) begin
          if (q32.size() == 0) check_eq("extra_done32", 64'd1, 64'd0);
          else begin
            e = q32.pop_front();
            $display("w32 %s result=%h dz=%b ill=%b cycle=%0d", e.tag, result32, dz32, ill32, cyc);
            check_eq({e.tag, "_res"}, 64'(result32), e.res);
            check_eq({e.tag, "_dz"}, 64'(dz32), 64'(e.dz));
            check_eq({e.tag, "_ill"}, 64'(ill32), 64'(e.ill));
            check_eq({e.tag, "_cycle"}, 64'(cyc), 64'(e.due));
            check_eq({e.tag, "_busy"}, 64'(bcnt), 64'(e.lat));
          end
          bcnt = 0;
        end
      end
    end
  end

  initial begin
    exp_t e;
    int   bcnt = 0;
    forever begin
      @(negedge clk);
      if (reset) bcnt = 0;
      else begin
        if (busy16) bcnt++;
        if (done16) begin
          if (q16.size() == 0) check_eq("extra_done16", 64'd1, 64'd0);
          else begin
            e = q16.pop_front();
            $display("w16 %s result=%h dz=%b ill=%b cycle=%0d", e.tag, result16, dz16, ill16, cyc);
            check_eq({e.tag, "_res"}, 64'(result16), e.res);
            check_eq({e.tag, "_dz"}, 64'(dz16), 64'(e.dz));
            check_eq({e.tag, "_ill"}, 64'(ill16), 64'(e.ill));
            check_eq({e.tag, "_cycle"}, 64'(cyc), 64'(e.due));
            check_eq({e.tag, "_busy"}, 64'(bcnt), 64'(e.lat));
          end
          bcnt = 0;
        end
      end
    end
  end

  function automatic int qsize(input bit w16);
    return w16 ? q16.size() : q32.size();
  endfunction

  task automatic wait_drain(input bit w16);
    for (int i = 0; i < 200 && qsize(w16) != 0; i++) @(negedge clk);
    if (qsize(w16) != 0) begin
      check_eq("timeout", 64'd1, 64'd0);
      if (w16) q16.delete(); else q32.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Drive one request, push its expectation after the accepting edge, then scramble operands.
  task automatic issue(input bit w16, input string tag, input logic [4:0] f,
                       input logic [63:0] av, input logic [63:0] bv,
                       input logic [63:0] er, input logic edz, input logic eill, input int lat);
    exp_t e;
    @(negedge clk);
    if (w16) begin start16 = 1'b1; func16 = f; a16 = av[15:0]; b16 = bv[15:0]; end
    else     begin start32 = 1'b1; func32 = f; a32 = av[31:0]; b32 = bv[31:0]; end
    @(posedge clk);
    #1;
    e.tag = tag; e.res = er; e.dz = edz; e.ill = eill; e.due = cyc + lat - 1; e.lat = lat;
    if (w16) begin q16.push_back(e); start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); end
    else     begin q32.push_back(e); start32 = 1'b0; a32 = $urandom; b32 = $urandom; end
  endtask

  task automatic run_op(input bit w16, input string tag, input logic [4:0] f,
                        input logic [63:0] av, input logic [63:0] bv,
                        input logic [63:0] er, input logic edz, input logic eill, input int lat);
    issue(w16, tag, f, av, bv, er, edz, eill, lat);
    wait_drain(w16);
  endtask

  function automatic logic [31:0] model32(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (f)
      OP2_ADD: return 32'(sa + sb);
      OP2_SUB: return 32'(sa - sb);
      OP2_MLT: return 32'(sa * sb);
      OP2_DIV: return 32'(sa / sb);
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  rf;
    logic [31:0] ra, rb;
    int          wi;
    reset = 1'b1;
    start32 = 1'b0; func32 = '0; a32 = '0; b32 = '0;
    start16 = 1'b0; func16 = '0; a16 = '0; b16 = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_out32", {busy32, done32, dz32, ill32, result32}, 64'd0);
    check_eq("rst_out16", {busy16, done16, dz16, ill16, result16}, 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_op(0, "add",      OP2_ADD,    7, 64'hFFFFFFFD, 64'd4, 0, 0, 1);
    run_op(0, "sub",      OP2_SUB,    5, 9, 64'hFFFFFFFC, 0, 0, 1);
    run_op(0, "not",      OP2_NOT,    64'h0F0F0F0F, 0, 64'hF0F0F0F0, 0, 0, 1);
    run_op(0, "and",      OP2_AND,    64'hFF00FF00, 64'h0FF00FF0, 64'h0F000F00, 0, 0, 1);
    run_op(0, "or",       OP2_OR,     64'hFF000000, 64'h000000FF, 64'hFF0000FF, 0, 0, 1);
    run_op(0, "xor",      OP2_XOR,    64'hFFFF0000, 64'h0FF00FF0, 64'hF00F0FF0, 0, 0, 1);
    run_op(0, "sul31",    OP2_SUL,    1, 31, 64'h80000000, 0, 0, 1);
    run_op(0, "ssl32",    OP2_SSL,    1, 32, 64'd0, 0, 0, 1);
    run_op(0, "sur4",     OP2_SUR,    64'h80000000, 4, 64'h08000000, 0, 0, 1);
    run_op(0, "sur100",   OP2_SUR,    64'h80000000, 100, 64'd0, 0, 0, 1);
    run_op(0, "ssr4",     OP2_SSR,    64'h80000000, 4, 64'hF8000000, 0, 0, 1);
    run_op(0, "ssr40",    OP2_SSR,    64'h80000000, 40, 64'hFFFFFFFF, 0, 0, 1);
    run_op(0, "ssr40pos", OP2_SSR,    64'h40000000, 40, 64'd0, 0, 0, 1);
    run_op(0, "eq",       OP2_EQ,     5, 5, 64'd1, 0, 0, 1);
    run_op(0, "neq",      OP2_NEQ,    5, 5, 64'd0, 0, 0, 1);
    run_op(0, "lt_sgn",   OP2_LT,     64'hFFFFFFFF, 1, 64'd1, 0, 0, 1);
    run_op(0, "leq_eq",   OP2_LEQ,    3, 3, 64'd1, 0, 0, 1);
    run_op(0, "leq_gt",   OP2_LEQ,    4, 3, 64'd0, 0, 0, 1);
    run_op(0, "bitsel1",  OP3_BITSEL, 64'hAABBCCDD, 1, 64'hBB, 0, 0, 1);
    run_op(0, "bitsel5",  OP3_BITSEL, 64'hAABBCCDD, 5, 64'hBB, 0, 0, 1);
    run_op(0, "bitsel0",  OP3_BITSEL, 64'hAABBCCDD, 0, 64'hAA, 0, 0, 1);
    run_op(0, "bitsel3",  OP3_BITSEL, 64'hAABBCCDD, 3, 64'hDD, 0, 0, 1);
    run_op(0, "illegal",  5'b10001,   64'h1234, 64'h5678, 64'd0, 0, 1, 1);

    // MLT with a start ignored mid-operation and another ignored on the done cycle.
    issue(0, "mlt", OP2_MLT, 64'hFFFFFFFA, 7, 64'hFFFFFFD6, 0, 0, 33);
    repeat (9) @(posedge clk);
    @(negedge clk);
    start32 = 1'b1; func32 = OP2_ADD; a32 = 1; b32 = 1;
    @(posedge clk);
    #1 start32 = 1'b0;
    wi = 0;
    while (!done32 && wi < 100) begin @(negedge clk); wi++; end
    check_eq("mlt_done_seen", 64'(done32), 64'd1);
    start32 = 1'b1;
    @(posedge clk);
    #1 start32 = 1'b0;
    repeat (40) @(negedge clk);
    wait_drain(0);

    run_op(0, "div_neg",  OP2_DIV, 64'hFFFFFFF9, 2, 64'hFFFFFFFD, 0, 0, 34);
    run_op(0, "div_min",  OP2_DIV, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 0, 0, 34);
    run_op(0, "div_zero", OP2_DIV, 5, 0, 64'hFFFFFFFF, 1, 0, 1);

    // Reset in the middle of a DIV: outputs clear at once and no done follows.
    @(negedge clk);
    start32 = 1'b1; func32 = OP2_DIV; a32 = 32'hFFFFFFF9; b32 = 2;
    @(posedge clk);
    #1 start32 = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    check_eq("div_busy_pre_rst", 64'(busy32), 64'd1);
    reset = 1'b1;
    #1;
    check_eq("rst_mid_busy", 64'(busy32), 64'd0);
    check_eq("rst_mid_done", 64'(done32), 64'd0);
    check_eq("rst_mid_res",  64'(result32), 64'd0);
    check_eq("rst_mid_dz",   64'(dz32), 64'd0);
    check_eq("rst_mid_ill",  64'(ill32), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    run_op(0, "add_after_rst", OP2_ADD, 1, 1, 64'd2, 0, 0, 1);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = 32'($signed($urandom) >>> $urandom_range(0, 28));
      case (i % 4)
        0: rf = OP2_ADD;
        1: rf = OP2_SUB;
        2: rf = OP2_MLT;
        default: rf = OP2_DIV;
      endcase
      if (rf == OP2_DIV && rb == 0) rb = 3;
      if (rf == OP2_DIV && ra == 32'h80000000) ra = 1;
      run_op(0, "rnd", rf, 64'(ra), 64'(rb), 64'(model32(rf, ra, rb)), 0, 0,
             (rf == OP2_MLT) ? 33 : (rf == OP2_DIV) ? 34 : 1);
    end

    run_op(1, "w16_illegal", 5'b01100,   64'h00FF, 64'h0003, 64'd0, 0, 1, 1);
    run_op(1, "w16_mlt",     OP2_MLT,    64'h0100, 64'h0100, 64'h0000, 0, 0, 17);
    run_op(1, "w16_mlt_neg", OP2_MLT,    64'hFFFD, 64'h0005, 64'hFFF1, 0, 0, 17);
    run_op(1, "w16_div",     OP2_DIV,    64'hFF9C, 64'h0007, 64'hFFF2, 0, 0, 18);
    run_op(1, "w16_div_min", OP2_DIV,    64'h8000, 64'hFFFF, 64'h8000, 0, 0, 18);
    run_op(1, "w16_bitsel",  OP3_BITSEL, 64'h1234, 64'h0003, 64'h0034, 0, 0, 1);
    run_op(1, "w16_ssr16",   OP2_SSR,    64'h8001, 64'h0010, 64'hFFFF, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/niu_mc_alu.md
NIU_MC_ALU -- requirements
Module: niu_mc_alu

Interface
REQ-001 SHALL have parameter WIDTH, 32, datapath width in bits; legal values are multiples of 8, from 8 to 64.
REQ-002 SHALL have parameter SHAMT_BITS, $clog2(WIDTH), number of shift-amount bits examined.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: start  input  1  request; accepted only when busy=0.
REQ-006 Port: func  input  5  operation code, using the secondary opcode set plus BITSEL (5'b11111).
REQ-007 Port: a  input  WIDTH  operand A, signed.
REQ-008 Port: b  input  WIDTH  operand B, signed.
REQ-009 Port: busy  output  1  high from the cycle after acceptance until the cycle done is high, inclusive.
REQ-010 Port: done  output  1  one-cycle pulse; result is valid.
REQ-011 Port: result  output  WIDTH  operation result; held until the next done.
REQ-012 Port: div_zero  output  1  DIV attempted with b=0; valid with done.
REQ-013 Port: illegal  output  1  func is not a defined code; valid with done.

Function
REQ-014 SHALL latch a, b and func on the accepting edge; later operand changes SHALL have no effect on the operation in flight.
REQ-015 SHALL use states IDLE, MUL, DIV, FIX and DONE; DONE asserts done for exactly one cycle, then the block returns to IDLE.
REQ-016 Single-cycle ops (SUB, ADD, NOT, AND, OR, XOR, shifts, compares, BITSEL): IDLE->DONE; done is high the cycle after acceptance (latency 1).
REQ-017 MLT: shift-add over WIDTH iterations in MUL; result is the low WIDTH bits of the signed product; latency WIDTH+1.
REQ-018 DIV: restoring division on magnitudes over WIDTH iterations in DIV, then one FIX cycle for the sign; quotient truncates toward zero; latency WIDTH+2.
REQ-019 DIV with b=0: no iteration; result all-ones and div_zero=1 at latency 1.
REQ-020 DIV of most-negative by -1: result is most-negative (wraps), div_zero=0.
REQ-021 SUL/SSL: shift left by b; SUR: logical right shift; SSR: arithmetic right shift. If b is unsigned and >= WIDTH, the result is 0, or all sign bits for SSR.
REQ-022 EQ, NEQ, LT and LEQ use signed compare; the result is 1 or 0, zero-extended.
REQ-023 BITSEL: k = b mod (WIDTH/8); lane 0 is the most-significant byte; result is byte k of a, zero-extended.
REQ-024 Undefined func: result 0 and illegal=1 at latency 1.
REQ-025 start while busy=1 SHALL be ignored and not queued; start in the same cycle as done SHALL be ignored.
REQ-026 div_zero and illegal SHALL be updated only with done and held with result.

Reset
REQ-027 reset SHALL force state IDLE and busy=0, done=0, result=0, div_zero=0, illegal=0 immediately.
REQ-028 reset mid-MUL or mid-DIV SHALL abort the operation with no done pulse; the first start after deassertion is accepted normally.

Structure
REQ-029 Opcode constants (OP2_* and OP3_BITSEL) and WORD_SIZE SHALL live in shared package niu_pkg, and the CPU SHALL use the same package.
REQ-030 The iterative engine SHALL be sub-module niu_iter_muldiv, with inputs start, mode, magnitudes and sign, and outputs value and done; all other logic stays in the top level.

Verification
REQ-031 WIDTH=32, ADD a=7, b=-3 -> done at cycle 1, result=4, busy high for 1 cycle.
REQ-032 MLT a=-6, b=7 -> done at cycle 33, result=-42; start pulsed at cycle 10 ignored, and no second done.
REQ-033 DIV a=-7, b=2 -> result=-3 at cycle 34; DIV a=5, b=0 -> div_zero=1, result=32'hFFFFFFFF at cycle 1.
REQ-034 BITSEL a=32'hAABBCCDD, b=1 -> 32'h000000BB; b=5 -> 32'h000000BB (k=1); SSR a=32'h80000000, b=40 -> 32'hFFFFFFFF.
REQ-035 Assert reset at cycle 15 of DIV -> outputs 0 at once and no done; the next ADD 1+1 gives 2 at latency 1.
REQ-036 WIDTH=16, func=5'b01100 -> illegal=1, result=0; MLT 16'h0100*16'h0100 -> 16'h0000 at latency 17.
